bram_port_arbiter: RTL and testbench

Shares one port of the team's dual-ported write-first block RAM between two requesters (requester 0 = fetch/loader, requester 1 = data/debug). It applies round-robin arbitration, drives the RAM port, and tracks in-flight reads through the RAM's 1- or 2-cycle read pipeline. Returned read data is steered into per-requester response FIFOs with valid/ready handshakes. Read issue is credit-gated, so RAM data is never dropped.

---
 rtl/bram_arb_pkg.sv | 11 +
 rtl/bram_resp_fifo.sv | 51 +++++
 rtl/bram_port_arbiter.sv | 85 ++++++++
 tb/tb_bram_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared latency/depth helpers and types for the BRAM port arbiter
package bram_arb_pkg;
   localparam int CNT_W = 3;
   typedef logic req_id_t;
   function automatic int lat(input bit pipelined);
      return pipelined ? 2 : 1;
   endfunction
   function automatic int resp_depth(input bit pipelined);
      return lat(pipelined) + 2;
   endfunction
endpackage

// File: rtl/bram_resp_fifo.sv
// bram_resp_fifo: first-word-fall-through response FIFO over registered storage
module bram_resp_fifo
   import bram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int DEPTH      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_W-1:0]      count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   assign empty = cnt_q == '0;
   assign full  = cnt_q == CNT_W'(DEPTH);
   assign count = cnt_q;
   assign dout  = mem_q[rd_q];
   // A pop frees the slot being read, so a full FIFO may push in the same cycle
   always_comb begin
      do_pop = pop && !empty;
      do_push = push && (!full || do_pop);
      mem_d = mem_q;
      mem_d[wr_q] = do_push ? din : mem_q[wr_q];
      rd_d = do_pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
      wr_d = do_push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         rd_q <= '0;
         wr_q <= '0;
         cnt_q <= '0;
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin share of one BRAM port between two requesters with credit-gated reads
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 1,
   parameter int DATA_WIDTH = 1,
   parameter bit PIPELINED  = 1'b0
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_data,
   output logic [1:0]              resp_valid,
   input  logic [1:0]              resp_ready,
   output logic [2*DATA_WIDTH-1:0] resp_data,
   output logic                    bram_en,
   output logic                    bram_we,
   output logic [ADDR_WIDTH-1:0]   bram_addr,
   output logic [DATA_WIDTH-1:0]   bram_din,
   input  logic [DATA_WIDTH-1:0]   bram_dout
);
   localparam int LAT = lat(PIPELINED);
   localparam int DEPTH = resp_depth(PIPELINED);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   logic [LAT-1:0] pv_q, pv_d;
   req_id_t [LAT-1:0] pid_q, pid_d;
   logic rr_q, rr_d;
   logic [1:0] elig, grant, push, pop, full, empty;
   logic [CNT_W-1:0] cnt [2];
   logic [CNT_W-1:0] used [2];
   req_id_t gid;
   assign resp_valid = ~empty;
   assign pop = ~empty & resp_ready;
   // Credit: reads in flight plus queued responses must never exceed the FIFO depth
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         used[i] = cnt[i];
         for (int s = 0; s < LAT; s++)
            used[i] = used[i] + CNT_W'(pv_q[s] && pid_q[s] == req_id_t'(i));
         elig[i] = !RST && req_valid[i] && (req_write[i] || (!full[i] && used[i] < DEPTH_C));
         push[i] = pv_q[LAT-1] && pid_q[LAT-1] == req_id_t'(i);
      end
      grant = &elig ? (rr_q ? 2'b10 : 2'b01) : elig;
      gid = req_id_t'(grant[1]);
      rr_d = |grant ? grant[0] : rr_q;
      req_ready = grant;
      bram_en = |grant;
      bram_we = bram_en && req_write[gid];
      bram_addr = gid ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      bram_din = gid ? req_data[2*DATA_WIDTH-1:DATA_WIDTH] : req_data[DATA_WIDTH-1:0];
      pv_d[0] = bram_en && !bram_we;
      pid_d[0] = gid;
      for (int s = 1; s < LAT; s++) begin
         pv_d[s] = pv_q[s-1];
         pid_d[s] = pid_q[s-1];
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         pv_q <= '0;
         pid_q <= '0;
         rr_q <= 1'b0;
      end else begin
         pv_q <= pv_d;
         pid_q <= pid_d;
         rr_q <= rr_d;
      end
   end
   for (genvar g = 0; g < 2; g++) begin : g_fifo
      bram_resp_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
         .clk   (CLK),
         .rst   (RST),
         .push  (push[g]),
         .din   (bram_dout),
         .pop   (pop[g]),
         .dout  (resp_data[g*DATA_WIDTH +: DATA_WIDTH]),
         .full  (full[g]),
         .empty (empty[g]),
         .count (cnt[g])
      );
   end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed checks of the arbiter at read latency 1 (u_a) and 2 (u_b)
module tb_bram_port_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   logic [1:0] a_rv, a_rw, a_qr, a_sv, a_rr, b_rv, b_rw, b_qr, b_sv, b_rr;
   logic [7:0] a_ra, b_ra, a_bd, b_bd, a_bo, b_bo, b_q;
   logic [15:0] a_rd, a_sd, b_rd, b_sd;
   logic a_en, a_we, b_en, b_we;
   logic [3:0] a_ba, b_ba;
   logic [7:0] a_mem [16];
   logic [7:0] b_mem [16];
   int n_chk = 0;
   int n_fail = 0;
   typedef struct packed {
      logic       rv;
      logic [3:0] a;
      logic       rr;
      logic       qr;
      logic       sv;
      logic [7:0] sd;
   } vec_t;
   vec_t tv [20] = '{
      '{1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b1, 4'd10, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b1, 4'd11, 1'b0, 1'b1, 1'b1, 8'h80},
      '{1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 8'h80},
      '{1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 8'h80},
      '{1'b1, 4'd12, 1'b1, 1'b0, 1'b1, 8'h80},
      '{1'b1, 4'd12, 1'b1, 1'b1, 1'b1, 8'h81},
      '{1'b1, 4'd13, 1'b1, 1'b1, 1'b1, 8'h82},
      '{1'b1, 4'd14, 1'b1, 1'b1, 1'b1, 8'h83},
      '{1'b1, 4'd15, 1'b0, 1'b1, 1'b1, 8'h84},
      '{1'b1, 4'd8,  1'b0, 1'b0, 1'b1, 8'h84},
      '{1'b1, 4'd8,  1'b0, 1'b0, 1'b1, 8'h84},
      '{1'b1, 4'd8,  1'b1, 1'b0, 1'b1, 8'h84},
      '{1'b1, 4'd8,  1'b1, 1'b1, 1'b1, 8'h85},
      '{1'b1, 4'd9,  1'b1, 1'b1, 1'b1, 8'h86},
      '{1'b0, 4'd9,  1'b1, 1'b0, 1'b1, 8'h87},
      '{1'b0, 4'd9,  1'b1, 1'b0, 1'b1, 8'h80},
      '{1'b0, 4'd9,  1'b1, 1'b0, 1'b1, 8'h81},
      '{1'b0, 4'd9,  1'b0, 1'b0, 1'b0, 8'h00}
   };

   bram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .PIPELINED(1'b0)) u_a (
      .CLK(clk), .RST(rst), .req_valid(a_rv), .req_ready(a_qr), .req_write(a_rw),
      .req_addr(a_ra), .req_data(a_rd), .resp_valid(a_sv), .resp_ready(a_rr),
      .resp_data(a_sd), .bram_en(a_en), .bram_we(a_we), .bram_addr(a_ba),
      .bram_din(a_bd), .bram_dout(a_bo)
   );
   bram_port_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .PIPELINED(1'b1)) u_b (
      .CLK(clk), .RST(rst), .req_valid(b_rv), .req_ready(b_qr), .req_write(b_rw),
      .req_addr(b_ra), .req_data(b_rd), .resp_valid(b_sv), .resp_ready(b_rr),
      .resp_data(b_sd), .bram_en(b_en), .bram_we(b_we), .bram_addr(b_ba),
      .bram_din(b_bd), .bram_dout(b_bo)
   );

   // Write-first RAM ports: 1-cycle read for u_a, extra output register for u_b
   always @(posedge clk) begin
      if (a_en) begin
         if (a_we) a_mem[a_ba] <= a_bd;
         a_bo <= a_we ? a_bd : a_mem[a_ba];
      end
   end
   always @(posedge clk) begin
      if (b_en) begin
         if (b_we) b_mem[b_ba] <= b_bd;
         b_q <= b_we ? b_bd : b_mem[b_ba];
      end
      b_bo <= b_q;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      a_rv = 2'b11; a_rw = 2'b00; a_ra = 8'h00; a_rd = 16'h0000; a_rr = 2'b00;
      b_rv = 2'b01; b_rw = 2'b00; b_ra = 8'h00; b_rd = 16'h0000; b_rr = 2'b00;
      tick();
      tick();
      chk("rst_a_ready", 16'(a_qr), 16'h0);
      chk("rst_a_en_we", 16'({a_en, a_we}), 16'h0);
      chk("rst_a_resp", 16'(a_sv), 16'h0);
      chk("rst_b_ready", 16'(b_qr), 16'h0);
      chk("rst_b_en", 16'(b_en), 16'h0);
      chk("rst_b_resp", 16'(b_sv), 16'h0);
      rst = 1'b0; a_rv = 2'b00; b_rv = 2'b00;

      // write A5 @3 by req0, then read @3 by req1
      a_rv = 2'b01; a_rw = 2'b01; a_ra = 8'h03; a_rd = 16'h00A5;
      #1;
      chk("t1_wr_ready", 16'(a_qr), 16'h1);
      chk("t1_wr_en_we", 16'({a_en, a_we}), 16'h3);
      chk("t1_wr_addr", 16'(a_ba), 16'h3);
      chk("t1_wr_din", 16'(a_bd), 16'hA5);
      tick();
      a_rv = 2'b10; a_rw = 2'b00; a_ra = 8'h30;
      #1;
      chk("t1_rd_ready", 16'(a_qr), 16'h2);
      chk("t1_rd_en_we", 16'({a_en, a_we}), 16'h2);
      chk("t1_rd_addr", 16'(a_ba), 16'h3);
      tick();
      a_rv = 2'b00;
      #1;
      chk("t1_resp_early", 16'(a_sv), 16'h0);
      tick();
      chk("t1_resp_valid", 16'(a_sv), 16'h2);
      chk("t1_resp_data", 16'(a_sd[15:8]), 16'hA5);
      a_rr = 2'b10;
      tick();
      a_rr = 2'b00;
      chk("t1_popped", 16'(a_sv), 16'h0);

      // both requesters read continuously: grants alternate starting with req0
      a_rv = 2'b11; a_rw = 2'b11; a_ra = 8'h21; a_rd = 16'h2211;
      #1;
      chk("t2_w0", 16'(a_qr), 16'h1);
      tick();
      a_rv = 2'b10;
      #1;
      chk("t2_w1", 16'(a_qr), 16'h2);
      tick();
      a_rv = 2'b11; a_rw = 2'b00; a_rr = 2'b11;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("t2_grant%0d", i), 16'(a_qr), (i % 2) ? 16'h2 : 16'h1);
         chk($sformatf("t2_resp%0d", i), 16'(a_sv), (i < 2) ? 16'h0 : ((i % 2) ? 16'h2 : 16'h1));
         if (i >= 2)
            chk($sformatf("t2_data%0d", i), 16'((i % 2) ? a_sd[15:8] : a_sd[7:0]), (i % 2) ? 16'h22 : 16'h11);
         tick();
      end
      a_rv = 2'b00;
      tick(); tick(); tick();
      a_rr = 2'b00;

      // req0 exhausts its credit; req1 writes win every cycle
      a_rv = 2'b01; a_rw = 2'b00; a_ra = 8'h01;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("t4_credit%0d", i), 16'(a_qr), (i < 3) ? 16'h1 : 16'h0);
         tick();
      end
      a_rv = 2'b11; a_rw = 2'b10;
      for (int i = 0; i < 3; i++) begin
         a_ra = {4'(5 + i), 4'd1}; a_rd = {8'(8'h55 + 8'(i) * 8'h11), 8'h00};
         #1;
         chk($sformatf("t4_wr_grant%0d", i), 16'(a_qr), 16'h2);
         chk($sformatf("t4_wr_we%0d", i), 16'({a_en, a_we}), 16'h3);
         tick();
      end
      a_rv = 2'b00; a_rr = 2'b01;
      #1;
      chk("t4_drain_valid", 16'(a_sv), 16'h1);
      chk("t4_drain_data", 16'(a_sd[7:0]), 16'h11);
      tick(); tick(); tick();
      chk("t4_drained", 16'(a_sv), 16'h0);
      a_rr = 2'b00;

      // reset with two reads in flight
      a_rv = 2'b11; a_rw = 2'b00; a_ra = 8'h65;
      #1;
      chk("t5_rd0", 16'(a_qr), 16'h1);
      tick();
      #1;
      chk("t5_rd1", 16'(a_qr), 16'h2);
      tick();
      a_rv = 2'b00; rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t5_flushed", 16'(a_sv), 16'h0);
      chk("t5_idle_en_we", 16'({a_en, a_we}), 16'h0);
      tick();
      chk("t5_no_stale", 16'(a_sv), 16'h0);
      a_rv = 2'b10; a_ra = 8'h60;
      #1;
      chk("t5_new_rd", 16'(a_qr), 16'h2);
      tick();
      a_rv = 2'b00;
      tick();
      chk("t5_new_valid", 16'(a_sv), 16'h2);
      chk("t5_new_data", 16'(a_sd[15:8]), 16'h66);
      a_rr = 2'b10;
      tick();
      a_rr = 2'b00;

      // latency-2 instance: preload 8..15 with 80..87, then the directed table
      b_rv = 2'b01; b_rw = 2'b01;
      for (int i = 0; i < 8; i++) begin
         b_ra = {4'd0, 4'(8 + i)}; b_rd = {8'h00, 8'(8'h80 + 8'(i))};
         tick();
      end
      b_rw = 2'b00;
      for (int i = 0; i < 20; i++) begin
         b_rv = {1'b0, tv[i].rv}; b_ra = {4'd0, tv[i].a}; b_rr = {1'b0, tv[i].rr};
         #1;
         chk($sformatf("p_ready%0d", i), 16'(b_qr), 16'({1'b0, tv[i].qr}));
         chk($sformatf("p_valid%0d", i), 16'(b_sv), 16'({1'b0, tv[i].sv}));
         if (tv[i].sv)
            chk($sformatf("p_data%0d", i), 16'(b_sd[7:0]), 16'(tv[i].sd));
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
